seg7_capture: RTL and testbench
===============================

# seg7_capture

Capture-side counterpart of the hex-to-7-segment display driver. The block samples a two-digit multiplexed 7-segment bus (active-low segments plus per-digit strobes), debounces each digit's pattern, decodes it back to a hex nibble, and delivers the reassembled byte over a valid/ready handshake. It sits on the debug path, where it lets a bench or a second FPGA read back what the display logic is driving.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit; legal range 1..255.
- CHANGE_ONLY, 1: when 1, suppress a byte equal to the last emitted byte. The first byte after reset is always emitted.
- clk  in  1  system clock; all inputs are synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- seg  in  7  segment bus, [6:0] = abcdefg, 0 = lit.
- dig_en  in  2  digit strobes, active-high; [0] = low-nibble digit, [1] = high-nibble digit.
- dout  out  8  captured byte, {hi, lo}.
- dout_valid  out  1  dout holds an unconsumed byte.
- dout_ready  in  1  consumer accepts dout on a cycle where dout_valid=1.
- bad_pattern  out  1  sticky: an accepted pattern matched no hex glyph.
- overrun  out  1  sticky: a complete pair was overwritten before it could be emitted.
- clr_err  in  1  synchronous clear of bad_pattern and overrun.

## Operation
- Decode table (pattern -> nibble):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b
  - 0110001->C, 1000010->d, 0110000->E, 0111000->F
  - Any other pattern is invalid.
- Digit select: dig_en=01 selects digit 0 and dig_en=10 selects digit 1. 00 and 11 are idle and set the stability counter to 0.
- Stability counter, per cycle with a valid select:
  - If {dig_en, seg} equals the previous sample, increment, saturating at STABLE_CYCLES.
  - Otherwise load 1.
- Acceptance: exactly one event per stable run, on the edge where the counter becomes STABLE_CYCLES. With STABLE_CYCLES=1, every change is accepted on its first sample.
  - Valid pattern: write nib[d] and set have[d]. Re-accepting a digit with have[d] already set overwrites nib[d] without error.
  - Invalid pattern: set bad_pattern and clear have[d].
  - If have==11 at the moment of a valid acceptance, set overrun, overwrite the nibble and keep have==11.
- Emit FSM:
  - States: COLLECT (have!=11), PENDING (have==11, output busy), EMIT.
  - COLLECT -> PENDING when have becomes 11.
  - PENDING -> load when dout_valid=0, or when dout_valid=1 and dout_ready=1 in the same cycle.
  - Load: dout={nib[1],nib[0]}, dout_valid=1, have cleared, return to COLLECT.
  - CHANGE_ONLY=1 and the pair equals the last emitted byte: clear have, leave dout and dout_valid unchanged, and count no overrun.
- Handshake:
  - dout_valid falls on the edge after dout_ready=1 unless a new load happens in that same cycle.
  - dout is stable while dout_valid=1 and dout_ready=0.
- Error flags: if clr_err and a new error set occur in the same cycle, the set wins.

## Timing
- Reset values: dout=00, dout_valid=0, bad_pattern=0, overrun=0, have=00, counter=0, emitted-flag clear.
- Acceptance latency: a digit stable from sample edge n is accepted at edge n+STABLE_CYCLES-1.
- Pair-to-output latency: dout_valid rises one edge after the edge that sets have to 11, provided the output is free.
- Example with STABLE_CYCLES=4: hi digit stable from edge n, accepted at n+3, dout_valid=1 after edge n+4.
- Throughput: one byte per cycle maximum; dout_ready may be held at 1 permanently.
- Reset asserted mid-capture: all state clears immediately (asynchronous); the partial pair is discarded.
- A strobe switch or a glitch of one sample restarts the counter. A run shorter than STABLE_CYCLES is never accepted.

## Test plan
- Reset, STABLE_CYCLES=4, dout_ready=1: drive seg=0010010 with dig_en=01 for 4 cycles, then seg=1001100 with dig_en=10 for 4 cycles -> one dout_valid pulse, dout=42, edge timing as stated above.
- Glitch: seg=0000110 for 3 cycles, a 1-cycle 0000000 glitch, then 4 cycles of 0000110 -> only the final run is accepted, as 3; no 8 is ever captured.
- Invalid glyph 1111110 on digit 0, held 4 cycles -> bad_pattern=1 and have[0]=0; clr_err together with a new invalid glyph leaves bad_pattern=1.
- Backpressure: dout_ready=0 with pairs 12 then 34 -> dout stays 12. A further valid acceptance while 34 is pending -> overrun=1. Raising dout_ready -> 34 (or its overwritten value) loads on the same edge that consumes 12.
- CHANGE_ONLY=1: continuous scan of digits 5,A -> exactly one byte, A5. Change the hi digit to C -> one byte, C5. With CHANGE_ONLY=0 the same scan gives A5 once per scan.
- Reset asserted between the lo and hi acceptances -> no byte emitted; the next full pair emits normally.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: samples a two-digit multiplexed 7-segment bus, debounces
// each digit, decodes it to hex and hands the byte out on valid/ready.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          CHANGE_ONLY   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg,
  input  logic [1:0] dig_en,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       bad_pattern,
  output logic       overrun,
  input  logic       clr_err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {
    COLLECT,
    PENDING
  } state_e;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [8:0] prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] have_q, have_d;
  logic [3:0] nib0_q, nib0_d;
  logic [3:0] nib1_q, nib1_d;
  logic [7:0] dout_q, dout_d;
  logic       dv_q, dv_d;
  logic       sent_q, sent_d;
  logic       bad_q, bad_d;
  logic       ovr_q, ovr_d;

  logic [8:0] smp;
  logic       sel_ok;
  logic       same;
  logic       acc;
  logic [4:0] dec;
  logic [7:0] pair;
  logic       load;
  logic       drop;
  logic [1:0] have_mid;
  logic       bad_set;
  logic       ovr_set;

  assign smp    = {dig_en, seg};
  assign sel_ok = (dig_en == 2'b01) || (dig_en == 2'b10);
  assign same   = (smp == prev_q);
  assign dec    = decode(seg);
  assign pair   = {nib1_q, nib0_q};

  // Accept once per run: when the counter reaches STABLE but not while parked there.
  always_comb begin
    cnt_d = '0;
    acc   = 1'b0;
    if (sel_ok) begin
      if (same) begin
        cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_d = 8'd1;
      end
      acc = (cnt_d == STABLE) && !(same && cnt_q == STABLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    nib0_d   = nib0_q;
    nib1_d   = nib1_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    sent_d   = sent_q;
    load     = 1'b0;
    drop     = 1'b0;
    bad_set  = 1'b0;
    ovr_set  = 1'b0;
    if (dout_ready) dv_d = 1'b0;
    if (state_q == PENDING) begin
      if (CHANGE_ONLY && sent_q && pair == dout_q) begin
        drop = 1'b1;
      end else if (!dv_q || dout_ready) begin
        load = 1'b1;
      end
    end
    if (load) begin
      dout_d = pair;
      dv_d   = 1'b1;
      sent_d = 1'b1;
    end
    have_mid = (load || drop) ? 2'b00 : have_q;
    have_d   = have_mid;
    if (acc) begin
      if (dec[4]) begin
        ovr_set = (have_mid == 2'b11);
        if (dig_en[1]) begin
          nib1_d    = dec[3:0];
          have_d[1] = 1'b1;
        end else begin
          nib0_d    = dec[3:0];
          have_d[0] = 1'b1;
        end
      end else begin
        bad_set = 1'b1;
        if (dig_en[1]) have_d[1] = 1'b0;
        else           have_d[0] = 1'b0;
      end
    end
    // A new error in the same cycle as clr_err takes priority.
    bad_d   = bad_set ? 1'b1 : (clr_err ? 1'b0 : bad_q);
    ovr_d   = ovr_set ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
    state_d = (have_d == 2'b11) ? PENDING : COLLECT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      prev_q  <= '0;
      cnt_q   <= '0;
      have_q  <= '0;
      nib0_q  <= '0;
      nib1_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      sent_q  <= 1'b0;
      bad_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= smp;
      cnt_q   <= cnt_d;
      have_q  <= have_d;
      nib0_q  <= nib0_d;
      nib1_q  <= nib1_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      sent_q  <= sent_d;
      bad_q   <= bad_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign bad_pattern = bad_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed checks of seg7_capture, one instance per
// CHANGE_ONLY setting driven by the same stimulus.
module tb_seg7_capture;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S4   = 7'b1001100;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S6   = 7'b0100000;
  localparam logic [6:0] S7   = 7'b0001111;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SC   = 7'b0110001;
  localparam logic [6:0] SBAD = 7'b1111110;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg = 7'h7f;
  logic [1:0] dig_en = 2'b00;
  logic       dout_ready = 1'b1;
  logic       clr_err = 1'b0;

  logic [7:0] dout1, dout0;
  logic       dv1, dv0, bad1, bad0, ovr1, ovr0;

  int checks = 0;
  int errors = 0;
  int n1, n0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  seg7_capture #(.STABLE_CYCLES(4), .CHANGE_ONLY(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .seg(seg), .dig_en(dig_en),
    .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready),
    .bad_pattern(bad1), .overrun(ovr1), .clr_err(clr_err)
  );

  seg7_capture #(.STABLE_CYCLES(4), .CHANGE_ONLY(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .seg(seg), .dig_en(dig_en),
    .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready),
    .bad_pattern(bad0), .overrun(ovr0), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dv1 && dout_ready) q1.push_back(dout1);
    if (dv0 && dout_ready) q0.push_back(dout0);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [1:0] d, input logic [6:0] s,
                      input int n);
    dig_en = d;
    seg    = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    hold(2'b00, 7'h7f, n);
  endtask

  initial begin
    #3;
    check("rst_dout", dout1, 8'h00);
    check("rst_valid", dv1, 1'b0);
    check("rst_bad", bad1, 1'b0);
    check("rst_ovr", ovr1, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // basic pair 42 and edge timing
    hold(2'b01, S2, 4);
    check("t1_lo_novalid", dv1, 1'b0);
    hold(2'b10, S4, 4);
    check("t1_hi_novalid", dv1, 1'b0);
    idle(1);
    check("t1_valid", dv1, 1'b1);
    check("t1_dout", dout1, 8'h42);
    idle(1);
    check("t1_valid_fall", dv1, 1'b0);
    check("t1_count", q1.size(), 1);

    // short run and glitch never accepted
    n1 = q1.size();
    hold(2'b10, S0, 4);
    hold(2'b01, S3, 3);
    hold(2'b01, S8, 1);
    idle(0);
    check("t2_none_yet", q1.size(), n1);
    hold(2'b01, S3, 4);
    idle(2);
    check("t2_count", q1.size(), n1 + 1);
    check("t2_byte", q1[n1], 8'h03);

    // invalid glyph clears have[0]
    n1 = q1.size();
    hold(2'b01, S7, 4);
    hold(2'b01, SBAD, 4);
    check("t3_bad", bad1, 1'b1);
    hold(2'b10, S1, 4);
    idle(2);
    check("t3_no_byte", q1.size(), n1);
    hold(2'b01, S7, 4);
    idle(2);
    check("t3_count", q1.size(), n1 + 1);
    check("t3_byte", q1[n1], 8'h17);
    clr_err = 1'b1;
    hold(2'b01, SBAD, 3);
    check("t3_clr", bad1, 1'b0);
    hold(2'b01, SBAD, 1);
    check("t3_set_wins", bad1, 1'b1);
    idle(1);
    clr_err = 1'b0;
    check("t3_clr_idle", bad1, 1'b0);

    // backpressure and overrun
    dout_ready = 1'b0;
    n1 = q1.size();
    hold(2'b01, S2, 4);
    hold(2'b10, S1, 4);
    idle(1);
    check("t4_valid", dv1, 1'b1);
    check("t4_dout12", dout1, 8'h12);
    hold(2'b01, S4, 4);
    hold(2'b10, S3, 4);
    idle(2);
    check("t4_stall", dout1, 8'h12);
    check("t4_no_ovr", ovr1, 1'b0);
    hold(2'b01, S5, 4);
    check("t4_ovr", ovr1, 1'b1);
    dout_ready = 1'b1;
    idle(1);
    check("t4_reload", dout1, 8'h35);
    check("t4_reload_v", dv1, 1'b1);
    idle(1);
    check("t4_fall", dv1, 1'b0);
    check("t4_count", q1.size(), n1 + 2);
    check("t4_first", q1[n1], 8'h12);
    check("t4_second", q1[n1+1], 8'h35);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("t4_ovr_clr", ovr1, 1'b0);

    // change-only suppression
    n1 = q1.size();
    n0 = q0.size();
    repeat (3) begin
      hold(2'b01, S5, 4);
      hold(2'b10, SA, 4);
    end
    idle(2);
    check("t5_co_count", q1.size(), n1 + 1);
    check("t5_co_byte", q1[n1], 8'hA5);
    check("t5_all_count", q0.size(), n0 + 3);
    check("t5_all_byte", q0[n0+2], 8'hA5);
    n1 = q1.size();
    n0 = q0.size();
    repeat (2) begin
      hold(2'b01, S5, 4);
      hold(2'b10, SC, 4);
    end
    idle(2);
    check("t5_c5_count", q1.size(), n1 + 1);
    check("t5_c5_byte", q1[n1], 8'hC5);
    check("t5_c5_all", q0.size(), n0 + 2);

    // reset between lo and hi acceptances
    n1 = 0;
    hold(2'b01, S6, 4);
    reset_n = 1'b0;
    q1.delete();
    #2;
    check("t6_rst_dout", dout1, 8'h00);
    check("t6_rst_valid", dv1, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(2'b10, S7, 4);
    idle(2);
    check("t6_no_byte", q1.size(), 0);
    hold(2'b01, S6, 4);
    hold(2'b10, S7, 4);
    idle(2);
    check("t6_count", q1.size(), 1);
    check("t6_byte", q1[0], 8'h76);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
